// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: 8x8 register memory with host port, SPI master streamer and SPI slave writer (option: SPI_MASTER_RX_EN)
module spi_mem_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              strans,
  input  logic              read_write_,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] madd,
  output logic [DATA_W-1:0] out,
  input  logic              miso,
  output logic              mosi,
  output logic              mclk,
  output logic              cs,
  input  logic              Mosi,
  input  logic              Mclk,
  input  logic              Cs,
  output logic              Miso
);
  localparam int BW = $clog2(DATA_W);
  localparam int CW = ADDR_W + BW;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] cnt, cnt_d, cnt_n;
  logic cs_d, mosi_d;
  logic [BW-1:0] sbit;
  logic [ADDR_W-1:0] saddr;
  logic [DATA_W-1:0] srx, sbyte;
  logic host_m, master_m, slave_act, slave_fire;
  assign host_m = enable & ~strans;
  assign master_m = ~enable & strans;
  assign slave_act = enable & strans & ~Cs;
  assign slave_fire = slave_act & Mclk & (&sbit);
  assign sbyte = {srx[DATA_W-2:0], Mosi};
  assign cnt_n = cnt + CW'(1);
  assign mclk = ~cs & ~clk;
  assign Miso = slave_act & mem[saddr][~sbit];
`ifdef SPI_MASTER_RX_EN
  logic miso_s, master_fire;
  logic [DATA_W-1:0] mrx;
  assign master_fire = master_m && state == SHIFT && (&cnt[BW-1:0]);
  // sample miso mid-bit, at the rising edge of mclk
  always_ff @(negedge clk or posedge rst)
    if (rst) miso_s <= 1'b0;
    else miso_s <= miso;
  // collect the byte returned while the current byte is shifted out
  always_ff @(posedge clk or posedge rst)
    if (rst) mrx <= '0;
    else if (master_m && state == SHIFT) mrx <= {mrx[DATA_W-2:0], miso_s};
`else
  logic unused_miso;
  assign unused_miso = miso;
`endif
  // master next state: first bit leaves on the IDLE->SHIFT edge so cs is low for exactly 64 bits
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    cs_d = cs;
    mosi_d = mosi;
    if (!master_m) begin
      state_d = IDLE;
      cnt_d = '0;
      cs_d = 1'b1;
      mosi_d = 1'b0;
    end else if (state == IDLE) begin
      state_d = SHIFT;
      cnt_d = '0;
      cs_d = 1'b0;
      mosi_d = mem[0][DATA_W-1];
    end else if (state == SHIFT) begin
      state_d = (&cnt) ? DONE : SHIFT;
      cnt_d = cnt_n;
      cs_d = &cnt;
      mosi_d = ~(&cnt) & mem[cnt_n[CW-1:BW]][~cnt_n[BW-1:0]];
    end
  end
  // master state and registered serial outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cs <= 1'b1;
      mosi <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      cs <= cs_d;
      mosi <= mosi_d;
    end
  // host read port, value held outside host reads
  always_ff @(posedge clk or posedge rst)
    if (rst) out <= '0;
    else if (host_m && read_write_) out <= mem[madd];
  // slave receiver: partial bytes are dropped whenever the slave is deselected
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sbit <= '0;
      srx <= '0;
      saddr <= '0;
    end else if (!slave_act) begin
      sbit <= '0;
      srx <= '0;
    end else if (Mclk) begin
      srx <= sbyte;
      sbit <= sbit + BW'(1);
      if (&sbit) saddr <= saddr + ADDR_W'(1);
    end
  // memory writes; modes are exclusive so at most one path fires per cycle
  always_ff @(posedge clk) begin
    if (host_m && !read_write_) mem[madd] <= data;
    if (slave_fire) mem[saddr] <= sbyte;
`ifdef SPI_MASTER_RX_EN
    if (master_fire) mem[cnt[CW-1:BW]] <= {mrx[DATA_W-2:0], miso_s};
`endif
  end
endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: randomized bench with a behavioural model of spi_mem_bridge
module tb_spi_mem_bridge;
  logic clk = 0, rst = 1, enable = 0, strans = 0, read_write_ = 1;
  logic [7:0] data = 0, out;
  logic [2:0] madd = 0;
  logic miso = 0, mosi, mclk, cs, Mosi = 0, Mclk = 0, Cs = 1, Miso;
  int n_cmp = 0, n_err = 0;
  spi_mem_bridge dut (
    .clk(clk), .rst(rst), .enable(enable), .strans(strans), .read_write_(read_write_),
    .data(data), .madd(madd), .out(out), .miso(miso), .mosi(mosi), .mclk(mclk), .cs(cs),
    .Mosi(Mosi), .Mclk(Mclk), .Cs(Cs), .Miso(Miso)
  );
  always #5 clk = ~clk;
  logic [7:0] mm [8];
  int t = 0, k = 0, a = 0;
  logic [7:0] acc_s = 0, acc_m = 0, e_out = 0;
  wire [1:0] mode = {enable, strans};
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; k = 0; a = 0; acc_s = 0; acc_m = 0; e_out = 0;
    end else begin
      if (mode == 2'b10) begin
        if (!read_write_) mm[madd] = data;
        else e_out = mm[madd];
      end
      if (mode == 2'b01) begin
`ifdef SPI_MASTER_RX_EN
        if (t >= 8 && t <= 64 && t % 8 == 0) mm[t/8-1] = acc_m;
`endif
        if (t < 65) t++;
      end else t = 0;
      if (mode == 2'b11 && !Cs) begin
        if (Mclk) begin
          acc_s = {acc_s[6:0], Mosi};
          k++;
          if (k == 8) begin
            mm[a] = acc_s;
            a = (a + 1) % 8;
            k = 0;
          end
        end
      end else begin
        k = 0; acc_s = 0;
      end
    end
  end
`ifdef SPI_MASTER_RX_EN
  always @(negedge clk)
    if (!rst && t >= 1 && t <= 64) acc_m = {acc_m[6:0], miso};
`endif
  always @(negedge clk) begin
    logic e_cs, e_mosi, e_miso;
    #1;
    e_cs = !(t >= 1 && t <= 64);
    e_mosi = e_cs ? 1'b0 : mm[(t-1)/8][7-((t-1)%8)];
    e_miso = (mode == 2'b11 && !Cs) ? mm[a][7-k] : 1'b0;
    check("out", 64'(out), 64'(e_out));
    check("cs", 64'(cs), 64'(e_cs));
    check("mosi", 64'(mosi), 64'(e_mosi));
    check("mclk", 64'(mclk), 64'(!e_cs));
    check("Miso", 64'(Miso), 64'(e_miso));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst;
    read_write_ = 1;
    rst = 1;
    tick;
    rst = 0;
  endtask
  task automatic read_chk(input int ad, input logic [7:0] exp);
    {enable, strans} = 2'b10;
    read_write_ = 1;
    madd = 3'(ad);
    tick;
    check($sformatf("read[%0d]", ad), 64'(out), 64'(exp));
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    Cs = 0;
    for (int i = 7; i > 7 - n; i--) begin
      Mosi = b[i];
      Mclk = 1;
      tick;
    end
    Mclk = 0;
  endtask
  task automatic capture(output int n, output logic [63:0] s);
    n = 0;
    s = 0;
    repeat (70) begin
      @(negedge clk);
      #1;
      if (!cs) begin
        n++;
        s = {s[62:0], mosi};
      end
    end
    tick;
  endtask
  initial begin
    logic [7:0] vals [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h70};
    logic [63:0] s;
    int n;
    tick;
    tick;
    rst = 0;
    check("reset_out", 64'(out), 64'h0);
    check("reset_cs", 64'(cs), 64'h1);
    {enable, strans} = 2'b10;
    for (int i = 0; i < 8; i++) begin
      read_write_ = 0; madd = 3'(i); data = vals[i];
      tick;
    end
    for (int i = 0; i < 8; i++) read_chk(i, vals[i]);
    pulse_rst;
    {enable, strans} = 2'b01;
    capture(n, s);
    check("cs_low_bits", 64'(n), 64'd64);
    check("mosi_stream", s, 64'h123456789ABCDE70);
    check("cs_after", 64'(cs), 64'h1);
    {enable, strans} = 2'b00;
    tick;
`ifndef SPI_MASTER_RX_EN
    for (int i = 0; i < 8; i++) read_chk(i, vals[i]);
`endif
    pulse_rst;
    {enable, strans} = 2'b11;
    send_bits(8'hCC, 8);
    send_bits(8'h72, 8);
    send_bits(8'hFF, 8);
    Cs = 1;
    tick;
    pulse_rst;
    read_chk(0, 8'hCC);
    read_chk(1, 8'h72);
    read_chk(2, 8'hFF);
    {enable, strans} = 2'b11;
    send_bits(8'hA5, 5);
    Cs = 1;
    tick;
    send_bits(8'h5A, 8);
    Cs = 1;
    tick;
    read_chk(0, 8'h5A);
    read_chk(1, 8'h72);
    {enable, strans} = 2'b01;
    repeat (20) tick;
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    check("rst_cs", 64'(cs), 64'h1);
    check("rst_mosi", 64'(mosi), 64'h0);
    check("rst_mclk", 64'(mclk), 64'h0);
    tick;
    rst = 0;
    capture(n, s);
    check("restart_bits", 64'(n), 64'd64);
`ifndef SPI_MASTER_RX_EN
    check("restart_stream", s, 64'h5A72FF789ABCDE70);
`endif
    for (int seg = 0; seg < 14; seg++) begin
      {enable, strans} = 2'($urandom);
      repeat ($urandom_range(4, 80)) begin
        read_write_ = 1'($urandom); data = 8'($urandom); madd = 3'($urandom);
        Mosi = 1'($urandom); Mclk = 1'($urandom); miso = 1'($urandom);
        Cs = ($urandom_range(0, 9) == 0);
        tick;
      end
    end
    {enable, strans} = 2'b00;
    Cs = 1; Mclk = 0; miso = 0;
    tick;
`ifdef SPI_MASTER_RX_EN
    pulse_rst;
    miso = 1;
    {enable, strans} = 2'b01;
    repeat (70) tick;
    miso = 0;
    for (int i = 0; i < 8; i++) read_chk(i, 8'hFF);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
